instr_issuer: RTL and testbench



---
 rtl/instr_issuer_pkg.sv | 17 +
 rtl/issue_fifo.sv | 58 +++++
 rtl/instr_issuer.sv | 119 +++++++++++
 tb/tb_instr_issuer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_issuer_pkg.sv
// Shared types and constants for the instruction issuer and its bench.
package instr_issuer_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } issuer_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/issue_fifo.sv
// Circular DEPTH x WIDTH instruction buffer with synchronous active-high reset.
module issue_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Buffers instruction words and issues them to mipscpu with a fixed execution window.
// Optional ISSUER_COUNT_EN adds a saturating issued_count output.
module instr_issuer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned EXEC_CYCLES = 5,
    parameter int unsigned INSTR_W     = instr_issuer_pkg::INSTR_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               load_ready,
    input  logic               start,
    output logic [INSTR_W-1:0] Instrword,
    output logic               Newinstr,
    output logic               busy,
    output logic               done,
    output logic               empty,
`ifdef ISSUER_COUNT_EN
    output logic [15:0]        issued_count,
`endif
    output logic               full
);

    import instr_issuer_pkg::*;

    localparam int unsigned CW = $clog2(EXEC_CYCLES) + 1;

    issuer_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [INSTR_W-1:0] head;
    logic [INSTR_W-1:0] instrword_q;
    logic               newinstr_q;
    logic               done_q;
    logic               pop;

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (Clock),
        .rst       (Reset),
        .push      (load_valid),
        .push_data (load_instr),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = empty ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(EXEC_CYCLES - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = empty ? DONE : ISSUE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Head is captured and popped on the edge that enters ISSUE, so Newinstr lines up with ISSUE.
    assign pop = (state_d == ISSUE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            instrword_q <= '0;
            newinstr_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            newinstr_q <= pop;
            done_q     <= (state_d == DONE);
            if (pop) begin
                instrword_q <= head;
            end
        end
    end

`ifdef ISSUER_COUNT_EN
    logic [15:0] issued_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            issued_q <= '0;
        end else if (state_q == IDLE && start) begin
            issued_q <= '0;
        end else if (state_q == ISSUE && issued_q != 16'hFFFF) begin
            issued_q <= issued_q + 1'b1;
        end
    end

    assign issued_count = issued_q;
`endif

    assign Instrword  = instrword_q;
    assign Newinstr   = newinstr_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign load_ready = !full;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed self-checking bench for instr_issuer.
module tb_instr_issuer;

    import instr_issuer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        load_valid;
    logic [31:0] load_instr;
    logic        load_ready;
    logic        start;
    logic [31:0] Instrword;
    logic        Newinstr;
    logic        busy;
    logic        done;
    logic        empty;
    logic        full;
`ifdef ISSUER_COUNT_EN
    logic [15:0] issued_count;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_words [16];

    instr_issuer #(
        .DEPTH       (8),
        .EXEC_CYCLES (5),
        .INSTR_W     (32)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .load_valid   (load_valid),
        .load_instr   (load_instr),
        .load_ready   (load_ready),
        .start        (start),
        .Instrword    (Instrword),
        .Newinstr     (Newinstr),
        .busy         (busy),
        .done         (done),
        .empty        (empty),
`ifdef ISSUER_COUNT_EN
        .issued_count (issued_count),
`endif
        .full         (full)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] enc_lw(input int rt, input int imm);
        logic [4:0] rt5;
        rt5 = rt[4:0];
        return {OP_LW, 5'd0, rt5, imm[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1;
        load_instr = w;
        tick();
        load_valid = 1'b0;
    endtask

    // Pulses start, then checks issue timing/order against exp_words; done expected at 6n+1.
    task automatic observe_run(input int n, input bit inject);
        int  k;
        bit  seen;
        k    = 0;
        seen = 0;
        start = 1'b1;
        for (int i = 1; i <= 6 * n + 10 && !seen; i++) begin
            tick();
            start      = 1'b0;
            load_valid = 1'b0;
            if (Newinstr) begin
                chk("issue_time", i, 1 + 6 * k);
                if (k < 16) chk("issue_word", Instrword, exp_words[k]);
                k++;
            end
            if (done) begin
                chk("done_time", i, 6 * n + 1);
                seen = 1;
            end
            if (inject && (i == 8 || i == 9)) begin
                load_valid = 1'b1;
                load_instr = exp_words[i];
            end
        end
        load_valid = 1'b0;
        chk("issue_count", k, n);
        chk("done_seen", {31'd0, seen}, 32'd1);
        tick();
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        Reset      = 1'b1;
        load_valid = 1'b0;
        load_instr = '0;
        start      = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_newinstr", {31'd0, Newinstr}, 32'd0);
        chk("rst_instrword", Instrword, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);

        // Six-word mipscpu program
        exp_words[0] = 32'h8C010000;
        exp_words[1] = 32'h8C020001;
        exp_words[2] = 32'h8C030002;
        exp_words[3] = 32'h00222020;
        exp_words[4] = 32'h00832822;
        exp_words[5] = 32'hAC050003;
        for (int i = 0; i < 6; i++) load_word(exp_words[i]);
        chk("prog_not_empty", {31'd0, empty}, 32'd0);
        observe_run(6, 1'b0);
        chk("instrword_hold", Instrword, 32'hAC050003);
        chk("prog_empty_after", {31'd0, empty}, 32'd1);
`ifdef ISSUER_COUNT_EN
        chk("issued_count", {16'd0, issued_count}, 32'd6);
`endif

        // Nine back-to-back pushes into an 8-deep buffer
        for (int i = 0; i < 8; i++) begin
            exp_words[i] = enc_lw(i + 1, 16 * i);
            load_word(exp_words[i]);
        end
        chk("full_after_8", {31'd0, full}, 32'd1);
        chk("ready_after_8", {31'd0, load_ready}, 32'd0);
        load_word(32'hDEADBEEF);
        chk("full_after_9", {31'd0, full}, 32'd1);
        observe_run(8, 1'b0);

        // Start with empty buffer
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_done", {31'd0, done}, 32'd1);
        chk("empty_start_newinstr", {31'd0, Newinstr}, 32'd0);
        chk("empty_start_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("empty_start_done_drop", {31'd0, done}, 32'd0);
        chk("empty_start_idle", {31'd0, busy}, 32'd0);
        chk("empty_start_no_word", Instrword, exp_words[7]);

        // Reset during WAIT after the third issue
        exp_words[0] = 32'h8C010000;
        exp_words[1] = 32'h8C020001;
        exp_words[2] = 32'h8C030002;
        exp_words[3] = 32'h00222020;
        exp_words[4] = 32'h00832822;
        exp_words[5] = 32'hAC050003;
        for (int i = 0; i < 6; i++) load_word(exp_words[i]);
        start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            start = 1'b0;
            if (i == 13) chk("third_issue", {31'd0, Newinstr}, 32'd1);
        end
        chk("third_word", Instrword, 32'h8C030002);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_newinstr", {31'd0, Newinstr}, 32'd0);
        chk("midrst_instrword", Instrword, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Newinstr) pulses++;
        end
        chk("midrst_no_issue", pulses, 0);

        // Load 8, then push 2 more mid-run to exercise pointer wrap
        for (int i = 0; i < 10; i++) exp_words[i] = enc_lw(i + 10, 100 + i);
        for (int i = 0; i < 8; i++) load_word(exp_words[i]);
        observe_run(10, 1'b1);
        chk("wrap_empty_after", {31'd0, empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
